vector_register_file: RTL
=========================

# vector_register_file

Parametrised vector register file for the vectorial ASIP datapath, succeeding the single enabled vector register. It holds DEPTH vector registers of LANES × WIDTH bits, with one masked write port (vector or scalar-broadcast mode), two independently enabled registered read ports with write-first forwarding, and a synchronous clear-all. It sits between decode (register addresses) and the vector ALU lanes (operands A/B, writeback).

## Interface
- WIDTH, 8, bits per lane element
- LANES, 4, elements per vector register (≥1)
- DEPTH, 8, number of vector registers (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), register address width (derived, not overridden)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of all registers
- we  in  1  write enable
- wmode  in  1  0 = vector write, 1 = broadcast wdata[0] to all lanes
- waddr  in  ADDR_W  write register index
- wmask  in  LANES  per-lane write enable; bit i gates lane i
- wdata  in  [LANES-1:0][WIDTH-1:0]  write data, lane 0 in low slice
- ren_a  in  1  read enable port A
- raddr_a  in  ADDR_W  read index port A
- rdata_a  out  [LANES-1:0][WIDTH-1:0]  registered read data port A
- ren_b  in  1  read enable port B
- raddr_b  in  ADDR_W  read index port B
- rdata_b  out  [LANES-1:0][WIDTH-1:0]  registered read data port B

## Operation
- Storage: DEPTH × LANES × WIDTH flops; no hardwired-zero register.
- Effective write lane value: wmode=0 → wdata[i]; wmode=1 → wdata[0] for every i.
- Write: at edge with we=1 and clr=0, lane i of reg[waddr] takes effective value iff wmask[i]=1; unmasked lanes keep old value. we=1 with wmask=0 is a no-op.
- Clear: clr=1 at an edge zeroes every lane of every register; clr has priority over we (write discarded that cycle).
- Read port X (A or B): at edge with ren_X=1, rdata_X loads the post-edge content of reg[raddr_X], i.e. write-first:
  - raddr_X == waddr, we=1, clr=0: masked lanes show new effective value, unmasked lanes show old content.
  - clr=1: rdata_X loads all zeros.
- ren_X=0: rdata_X holds its previous value regardless of writes/clears to the register last read.
- Ports A and B are independent; same address on both is legal and both return identical data.
- Reset (rst=1, any time, no clock needed): all registers and rdata_a, rdata_b = 0. Mid-operation reset discards any pending write; first edge after rst deasserts operates normally.
- No arithmetic; address values are always in range (DEPTH power of two), no wrap logic.

## Timing
- Write latency: 1 cycle; data visible in storage after the capturing edge.
- Read latency: 1 cycle; rdata_X valid after the edge at which ren_X was sampled high, held until next ren_X=1 edge.
- Write-to-read forwarding: 0 additional cycles (same-edge write-first as above).
- rst asserts outputs to 0 asynchronously; deassertion is sampled synchronously by downstream logic.
- All inputs sampled only at rising clk; no combinational path from inputs to outputs.

## Test plan
- Reset: drive rst=1 mid-run after writes → rdata_a = rdata_b = 0 immediately; read reg 3 after release → 0.
- Masked vector write: LANES=4, WIDTH=4; write reg 2 = {C,A,5,3} mask 1111, then {F,F,F,F} mask 0101; read A reg 2 → {C,F,5,F}.
- Broadcast: wmode=1, waddr=5, wdata lane0=9, mask 1011 over prior zeros → read B reg 5 = {9,0,9,9}.
- Write-first forwarding: same edge we=1 waddr=1 wdata={1,2,3,4} mask 1111, ren_a=1 raddr_a=1 → rdata_a={1,2,3,4} after that edge; port B reading reg 0 same edge unaffected.
- Read hold: ren_b=1 reads reg 4 = {7,7,7,7}; then ren_b=0 while reg 4 rewritten to {0,1,0,1} → rdata_b stays {7,7,7,7} until ren_b=1 again, then {0,1,0,1}.
- Clear priority: clr=1 with we=1 to reg 6 and ren_a=1 raddr_a=6 → rdata_a=0; every register reads 0 afterwards.

Source files
------------

// File: rtl/vector_register_file_if.sv
// Handshake-free register-file port bundle: decode/writeback drive it (master), the file serves it (slave).
// Read data is registered inside the file; nothing here carries backpressure.
interface vector_register_file_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                          clr;
  logic                          we;
  logic                          wmode;
  logic [ADDR_W-1:0]             waddr;
  logic [LANES-1:0]              wmask;
  logic [LANES-1:0][WIDTH-1:0]   wdata;
  logic                          ren_a;
  logic [ADDR_W-1:0]             raddr_a;
  logic [LANES-1:0][WIDTH-1:0]   rdata_a;
  logic                          ren_b;
  logic [ADDR_W-1:0]             raddr_b;
  logic [LANES-1:0][WIDTH-1:0]   rdata_b;

  modport master (
    output clr, we, wmode, waddr, wmask, wdata,
    output ren_a, raddr_a, ren_b, raddr_b,
    input  rdata_a, rdata_b
  );

  modport slave (
    input  clr, we, wmode, waddr, wmask, wdata,
    input  ren_a, raddr_a, ren_b, raddr_b,
    output rdata_a, rdata_b
  );
endinterface

// File: rtl/vector_register_file.sv
// Vector register file: DEPTH x LANES x WIDTH, masked/broadcast write, two write-first registered read ports.
// Write and read latency 1 cycle; always ready, no backpressure.
module vector_register_file #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  vector_register_file_if.slave  rf
);
  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  vec_t mem_q [DEPTH];
  vec_t mem_d [DEPTH];
  vec_t rdata_a_q, rdata_a_d;
  vec_t rdata_b_q, rdata_b_d;
  vec_t wr_vec;

  always_comb begin
    wr_vec    = '0;
    mem_d     = mem_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;

    for (int i = 0; i < LANES; i++) begin
      wr_vec[i] = rf.wmode ? rf.wdata[0] : rf.wdata[i];
    end

    if (rf.clr) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_d[r] = '0;
      end
    end else if (rf.we) begin
      for (int i = 0; i < LANES; i++) begin
        if (rf.wmask[i]) begin
          mem_d[rf.waddr][i] = wr_vec[i];
        end
      end
    end

    // Reading the next-state array gives write-first forwarding and zero-on-clear for free.
    if (rf.ren_a) begin
      rdata_a_d = mem_d[rf.raddr_a];
    end
    if (rf.ren_b) begin
      rdata_b_d = mem_d[rf.raddr_b];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= mem_d[r];
      end
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rf.rdata_a = rdata_a_q;
  assign rf.rdata_b = rdata_b_q;
endmodule
